// File: rtl/mc_datapath_core.sv
// Multi-cycle 16-bit-instruction core with req/ack instruction and data ports.
// Optional MUL (op B) is enabled by defining MCDP_MUL_EN.
module mc_datapath_core #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned CNT_W = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [15:0]       imem_rdata,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  input  logic              dmem_ack,
  input  logic [DATA_W-1:0] dmem_rdata,
  output logic              halted,
  output logic [CNT_W-1:0]  retired
);

  localparam int unsigned XW = (DATA_W > ADDR_W) ? DATA_W : ADDR_W;

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALTED
  } state_t;

  state_t            state_q, state_d;
  logic              run_q, run_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [15:0]       ir_q, ir_d;
  logic [DATA_W-1:0] a_q, a_d;
  logic [DATA_W-1:0] b_q, b_d;
  logic [DATA_W-1:0] rdv_q, rdv_d;
  logic [XW-1:0]     imm_q, imm_d;
  logic [DATA_W-1:0] res_q, res_d;
  logic [ADDR_W-1:0] ea_q, ea_d;
  logic [DATA_W-1:0] wd_q, wd_d;
  logic [CNT_W-1:0]  ret_q, ret_d;
  logic [DATA_W-1:0] rf_q [8];
  logic [DATA_W-1:0] rf_d [8];

  logic [3:0] op;
  logic [2:0] rd, ra, rb;
  logic is_alu, is_lw, is_sw, is_beq, is_jmp, is_halt, is_mul;
  logic [DATA_W-1:0] b_op, alu;
  logic [ADDR_W-1:0] pc_inc;

  assign op = ir_q[15:12];
  assign rd = ir_q[11:9];
  assign ra = ir_q[8:6];
  assign rb = ir_q[5:3];

  assign is_alu  = (op < 4'h7);
  assign is_lw   = (op == 4'h7);
  assign is_sw   = (op == 4'h8);
  assign is_beq  = (op == 4'h9);
  assign is_jmp  = (op == 4'hA);
  assign is_halt = (op == 4'hF);
`ifdef MCDP_MUL_EN
  assign is_mul  = (op == 4'hB);
`else
  assign is_mul  = 1'b0;
`endif

  assign pc_inc = pc_q + ADDR_W'(1);

  always_comb begin
    b_op = (op == 4'h6) ? imm_q[DATA_W-1:0] : b_q;
    case (op)
      4'h1:    alu = a_q - b_op;
      4'h2:    alu = a_q & b_op;
      4'h3:    alu = a_q | b_op;
      4'h4:    alu = a_q ^ b_op;
      4'h5:    alu = DATA_W'($signed(a_q) < $signed(b_op));
`ifdef MCDP_MUL_EN
      4'hB:    alu = DATA_W'(a_q * b_op);
`endif
      default: alu = a_q + b_op;
    endcase
  end

  always_comb begin
    state_d = state_q;
    run_d   = 1'b1;
    pc_d    = pc_q;
    ir_d    = ir_q;
    a_d     = a_q;
    b_d     = b_q;
    rdv_d   = rdv_q;
    imm_d   = imm_q;
    res_d   = res_q;
    ea_d    = ea_q;
    wd_d    = wd_q;
    ret_d   = ret_q;
    rf_d    = rf_q;
    case (state_q)
      S_FETCH: begin
        if (run_q && imem_ack) begin
          ir_d    = imem_rdata;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        a_d     = rf_q[ra];
        b_d     = rf_q[rb];
        rdv_d   = rf_q[rd];
        imm_d   = {{(XW-6){ir_q[5]}}, ir_q[5:0]};
        state_d = S_EXEC;
      end
      S_EXEC: begin
        unique case (1'b1)
          is_alu, is_mul: begin
            res_d   = alu;
            state_d = S_WB;
          end
          is_lw, is_sw: begin
            ea_d    = ADDR_W'(a_q) + imm_q[ADDR_W-1:0];
            wd_d    = rdv_q;
            state_d = S_MEM;
          end
          is_beq: begin
            pc_d    = (rdv_q == a_q) ? pc_inc + imm_q[ADDR_W-1:0] : pc_inc;
            ret_d   = ret_q + CNT_W'(1);
            state_d = S_FETCH;
          end
          is_jmp: begin
            pc_d    = ADDR_W'(ir_q[11:0]);
            ret_d   = ret_q + CNT_W'(1);
            state_d = S_FETCH;
          end
          is_halt: begin
            ret_d   = ret_q + CNT_W'(1);
            state_d = S_HALTED;
          end
          default: begin
            pc_d    = pc_inc;
            ret_d   = ret_q + CNT_W'(1);
            state_d = S_FETCH;
          end
        endcase
      end
      S_MEM: begin
        if (dmem_ack) begin
          if (is_sw) begin
            pc_d    = pc_inc;
            ret_d   = ret_q + CNT_W'(1);
            state_d = S_FETCH;
          end else begin
            res_d   = dmem_rdata;
            state_d = S_WB;
          end
        end
      end
      S_WB: begin
        if (rd != 3'd0) rf_d[rd] = res_q;
        pc_d    = pc_inc;
        ret_d   = ret_q + CNT_W'(1);
        state_d = S_FETCH;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_FETCH;
      run_q   <= 1'b0;
      pc_q    <= RESET_PC;
      ir_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      rdv_q   <= '0;
      imm_q   <= '0;
      res_q   <= '0;
      ea_q    <= '0;
      wd_q    <= '0;
      ret_q   <= '0;
      for (int i = 0; i < 8; i++) rf_q[i] <= '0;
    end else begin
      state_q <= state_d;
      run_q   <= run_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      a_q     <= a_d;
      b_q     <= b_d;
      rdv_q   <= rdv_d;
      imm_q   <= imm_d;
      res_q   <= res_d;
      ea_q    <= ea_d;
      wd_q    <= wd_d;
      ret_q   <= ret_d;
      rf_q    <= rf_d;
    end
  end

  // run_q keeps the fetch request low for the first cycle out of reset
  assign imem_req   = run_q && (state_q == S_FETCH);
  assign imem_addr  = pc_q;
  assign dmem_req   = (state_q == S_MEM);
  assign dmem_we    = (state_q == S_MEM) && is_sw;
  assign dmem_addr  = ea_q;
  assign dmem_wdata = wd_q;
  assign halted     = (state_q == S_HALTED);
  assign retired    = ret_q;

endmodule

// File: tb/tb_mc_datapath_core.sv
// Bench for mc_datapath_core: program vectors with a store scoreboard,
// plus hand sequences for branch loops, PC wrap, halt and reset.
module tb_mc_datapath_core;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req, imem_ack;
  logic [7:0]  imem_addr;
  logic [15:0] imem_rdata;
  logic        dmem_req, dmem_we, dmem_ack;
  logic [7:0]  dmem_addr, dmem_wdata, dmem_rdata;
  logic        halted;
  logic [15:0] retired;

  always #5 clk = ~clk;

  mc_datapath_core dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .halted(halted), .retired(retired)
  );

`ifdef MCDP_MUL_EN
  localparam int MULC = 4;
  localparam int MULR = 8'h20;
`else
  localparam int MULC = 3;
  localparam int MULR = 8'h07;
`endif

  typedef struct packed {
    logic [15:0][15:0] prog;
    logic [3:0][15:0]  st;
    int nst;
    int ilat;
    int dlat;
    int ret;
    int cyc;
  } vec_t;

  localparam int NV = 8;
  vec_t vecs [NV];

  int errors = 0;
  int checks = 0;
  int ilat = 0;
  int dlat = 0;
  int cyc;
  logic [15:0] imem [256];
  logic [7:0]  dmem [256];
  logic [15:0] sb [$];
  logic [7:0]  flog [$];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [15:0] enc_r(input int op, rd, ra, rb);
    return {op[3:0], rd[2:0], ra[2:0], rb[2:0], 3'b000};
  endfunction

  function automatic logic [15:0] enc_i(input int op, rd, ra, imm);
    return {op[3:0], rd[2:0], ra[2:0], imm[5:0]};
  endfunction

  function automatic logic [15:0] enc_j(input int op, imm);
    return {op[3:0], imm[11:0]};
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) cyc <= 0;
    else if (!halted) cyc <= cyc + 1;
  end

  // instruction memory with fixed ack latency
  initial begin
    int icnt;
    icnt = 0;
    imem_ack = 1'b0;
    imem_rdata = '0;
    forever begin
      @(negedge clk);
      if (rst || imem_ack) begin
        imem_ack = 1'b0;
        icnt = 0;
      end else if (imem_req) begin
        if (icnt >= ilat) begin
          imem_ack = 1'b1;
          imem_rdata = imem[imem_addr];
          flog.push_back(imem_addr);
        end else begin
          icnt++;
        end
      end
    end
  end

  // data memory; stores checked against the scoreboard
  initial begin
    int dcnt;
    logic [7:0] a0, w0;
    logic we0;
    logic [15:0] e;
    dcnt = 0;
    dmem_ack = 1'b0;
    dmem_rdata = '0;
    forever begin
      @(negedge clk);
      if (rst || dmem_ack) begin
        dmem_ack = 1'b0;
        dcnt = 0;
      end else if (dmem_req) begin
        if (dcnt == 0) begin
          a0 = dmem_addr;
          w0 = dmem_wdata;
          we0 = dmem_we;
        end else begin
          chk("dmem_addr_hold", dmem_addr, a0);
          chk("dmem_we_hold", dmem_we, we0);
          chk("dmem_wdata_hold", dmem_wdata, w0);
        end
        if (dcnt >= dlat) begin
          dmem_ack = 1'b1;
          if (dmem_we) begin
            dmem[dmem_addr] = dmem_wdata;
            if (sb.size() == 0) begin
              checks++;
              errors++;
              $display("FAIL store_unexpected: got %0h expected none",
                       {dmem_addr, dmem_wdata});
            end else begin
              e = sb.pop_front();
              chk("store_addr_data", {dmem_addr, dmem_wdata}, e);
            end
          end else begin
            dmem_rdata = dmem[dmem_addr];
          end
        end else begin
          dcnt++;
        end
      end
    end
  end

  task automatic setup(input int il, input int dl);
    rst = 1'b1;
    ilat = il;
    dlat = dl;
    sb.delete();
    flog.delete();
    for (int i = 0; i < 256; i++) begin
      imem[i] = 16'hF000;
      dmem[i] = 8'h00;
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic run_to_halt(input int budget);
    int n;
    n = 0;
    while (!halted && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("halt_reached", halted, 1'b1);
  endtask

  task automatic init_vec(input int i, il, dl, rt, cy);
    vecs[i].prog = {16{16'hF000}};
    vecs[i].st = '0;
    vecs[i].nst = 0;
    vecs[i].ilat = il;
    vecs[i].dlat = dl;
    vecs[i].ret = rt;
    vecs[i].cyc = cy;
  endtask

  task automatic add_st(input int i, input int a, input int d);
    vecs[i].st[vecs[i].nst] = {a[7:0], d[7:0]};
    vecs[i].nst++;
  endtask

  initial begin
    int n;
    logic [7:0] e2 [4];
    logic [7:0] e3 [4];

    // v0: basic ALU chain
    init_vec(0, 0, 0, 5, 20);
    vecs[0].prog[0] = enc_i(6, 1, 0, 5);
    vecs[0].prog[1] = enc_i(6, 2, 0, -3);
    vecs[0].prog[2] = enc_r(0, 3, 1, 2);
    vecs[0].prog[3] = enc_i(8, 3, 0, 0);
    add_st(0, 0, 2);
    // v1: logic ops and SUB
    init_vec(1, 0, 0, 11, 44);
    vecs[1].prog[0] = enc_i(6, 1, 0, 31);
    vecs[1].prog[1] = enc_i(6, 2, 0, -31);
    vecs[1].prog[2] = enc_r(1, 3, 1, 2);
    vecs[1].prog[3] = enc_r(2, 4, 1, 2);
    vecs[1].prog[4] = enc_r(3, 5, 1, 2);
    vecs[1].prog[5] = enc_r(4, 6, 1, 2);
    vecs[1].prog[6] = enc_i(8, 3, 0, 1);
    vecs[1].prog[7] = enc_i(8, 4, 0, 2);
    vecs[1].prog[8] = enc_i(8, 5, 0, 3);
    vecs[1].prog[9] = enc_i(8, 6, 0, 4);
    add_st(1, 1, 8'h3E);
    add_st(1, 2, 8'h01);
    add_st(1, 3, 8'hFF);
    add_st(1, 4, 8'hFE);
    // v2: signed SLT with 0x80
    init_vec(2, 0, 0, 10, 40);
    vecs[2].prog[0] = enc_i(6, 1, 0, -32);
    vecs[2].prog[1] = enc_r(0, 1, 1, 1);
    vecs[2].prog[2] = enc_r(0, 1, 1, 1);
    vecs[2].prog[3] = enc_i(6, 2, 0, 1);
    vecs[2].prog[4] = enc_r(5, 3, 1, 2);
    vecs[2].prog[5] = enc_r(5, 4, 2, 1);
    vecs[2].prog[6] = enc_i(8, 3, 0, 5);
    vecs[2].prog[7] = enc_i(8, 4, 0, 6);
    vecs[2].prog[8] = enc_i(8, 1, 0, 7);
    add_st(2, 5, 1);
    add_st(2, 6, 0);
    add_st(2, 7, 8'h80);
    // v3: r0 stays zero
    init_vec(3, 0, 0, 5, 20);
    vecs[3].prog[0] = enc_i(6, 0, 0, 7);
    vecs[3].prog[1] = enc_r(0, 1, 0, 0);
    vecs[3].prog[2] = enc_i(8, 1, 0, 8);
    vecs[3].prog[3] = enc_i(8, 0, 0, 9);
    add_st(3, 8, 0);
    add_st(3, 9, 0);
    // v4: store/load with 3-cycle data stalls
    init_vec(4, 0, 3, 7, 41);
    vecs[4].prog[0] = enc_i(6, 1, 0, 5);
    vecs[4].prog[1] = enc_i(8, 1, 0, 4);
    vecs[4].prog[2] = enc_i(7, 4, 0, 4);
    vecs[4].prog[3] = enc_i(8, 4, 0, 10);
    vecs[4].prog[4] = enc_i(6, 2, 0, 20);
    vecs[4].prog[5] = enc_i(8, 1, 2, -3);
    add_st(4, 4, 5);
    add_st(4, 10, 5);
    add_st(4, 17, 5);
    // v5: v0 with 2-cycle fetch stalls
    init_vec(5, 2, 0, 5, 30);
    vecs[5].prog = vecs[0].prog;
    add_st(5, 0, 2);
    // v6: branches and jump
    init_vec(6, 0, 0, 7, 25);
    vecs[6].prog[0] = enc_i(6, 1, 0, 1);
    vecs[6].prog[1] = enc_i(9, 1, 0, 3);
    vecs[6].prog[2] = enc_i(8, 1, 0, 11);
    vecs[6].prog[3] = enc_i(9, 0, 0, 1);
    vecs[6].prog[4] = enc_i(8, 1, 0, 12);
    vecs[6].prog[5] = enc_j(10, 8);
    vecs[6].prog[6] = enc_i(8, 1, 0, 13);
    vecs[6].prog[7] = enc_i(8, 1, 0, 13);
    vecs[6].prog[8] = enc_i(8, 1, 0, 14);
    add_st(6, 11, 1);
    add_st(6, 14, 1);
    // v7: MUL (or NOP) and explicit NOP
    init_vec(7, 0, 0, 7, 23 + MULC);
    vecs[7].prog[0] = enc_i(6, 1, 0, 8'h12);
    vecs[7].prog[1] = enc_i(6, 2, 0, 8'h10);
    vecs[7].prog[2] = enc_i(6, 3, 0, 7);
    vecs[7].prog[3] = enc_r(11, 3, 1, 2);
    vecs[7].prog[4] = 16'hC000;
    vecs[7].prog[5] = enc_i(8, 3, 0, 15);
    add_st(7, 15, MULR);

    // reset state
    setup(0, 0);
    chk("rst_imem_req", imem_req, 0);
    chk("rst_dmem_req", dmem_req, 0);
    chk("rst_dmem_we", dmem_we, 0);
    chk("rst_halted", halted, 0);
    chk("rst_retired", retired, 0);
    chk("rst_addrs", {imem_addr, dmem_addr, dmem_wdata}, 0);

    // first request timing and retire count after 12 instruction cycles
    for (int j = 0; j < 16; j++) imem[j] = vecs[0].prog[j];
    rst = 1'b0;
    #1;
    chk("req_low_after_rst", imem_req, 0);
    @(negedge clk);
    chk("req_rises_next_cycle", imem_req, 1);
    n = 0;
    while (cyc < 13 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("h1_cycle", cyc, 13);
    chk("h1_retired", retired, 3);

    for (int i = 0; i < NV; i++) begin
      setup(vecs[i].ilat, vecs[i].dlat);
      for (int j = 0; j < 16; j++) imem[j] = vecs[i].prog[j];
      for (int k = 0; k < vecs[i].nst; k++) sb.push_back(vecs[i].st[k]);
      rst = 1'b0;
      run_to_halt(400);
      chk($sformatf("v%0d_retired", i), retired, vecs[i].ret);
      chk($sformatf("v%0d_cycles", i), cyc, vecs[i].cyc);
      chk($sformatf("v%0d_sb_empty", i), sb.size(), 0);
    end

    // BEQ r0,r0,-1 loops on itself
    setup(0, 0);
    imem[0] = enc_j(10, 12'h010);
    imem[16] = enc_i(9, 0, 0, -1);
    e2 = '{8'h00, 8'h10, 8'h10, 8'h10};
    rst = 1'b0;
    repeat (20) @(negedge clk);
    chk("beq_nfetch", flog.size() >= 4, 1);
    for (int k = 0; k < 4; k++) chk($sformatf("beq_fetch%0d", k), flog[k], e2[k]);

    // JMP 0x0FF then PC wraps to 0
    setup(0, 0);
    imem[0] = enc_j(10, 12'h0FF);
    imem[255] = 16'hC000;
    e3 = '{8'h00, 8'hFF, 8'h00, 8'hFF};
    rst = 1'b0;
    repeat (20) @(negedge clk);
    chk("jmp_nfetch", flog.size() >= 4, 1);
    for (int k = 0; k < 4; k++) chk($sformatf("jmp_fetch%0d", k), flog[k], e3[k]);

    // HALT is absorbing
    setup(0, 0);
    rst = 1'b0;
    run_to_halt(20);
    n = 0;
    repeat (20) begin
      @(negedge clk);
      if (imem_req || dmem_req) n++;
    end
    chk("halt_no_req", n, 0);
    chk("halt_flag", halted, 1);
    chk("halt_retired", retired, 1);
    chk("halt_pc", imem_addr, 0);

    // async reset in the middle of a stalled fetch
    setup(4, 0);
    for (int j = 0; j < 16; j++) imem[j] = vecs[0].prog[j];
    rst = 1'b0;
    n = 0;
    while (!(retired == 1 && imem_req) && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("mid_fetch_reached", {retired == 1, imem_req}, 2'b11);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_reqs", {imem_req, dmem_req, dmem_we, halted}, 0);
    chk("arst_retired", retired, 0);
    chk("arst_addrs", {imem_addr, dmem_addr, dmem_wdata}, 0);
    repeat (2) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
